uart_transmitter: RTL and testbench

Serialises bytes onto an asynchronous UART line. Frame: one start bit (low), 8 data bits LSB first, optional parity bit, 1 or 2 stop bits (high). This is the transmit end of the serial link whose receive end is the existing UART receiver. Bytes arrive over a valid/ready interface from the CPU-side I/O logic. A one-entry holding register allows back-to-back frames with no idle gap.

---
 rtl/uart_transmitter.sv | 163 ++++++++++++++++
 tb/tb_uart_transmitter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits, fed through a one-entry holding register.
//
// Ports:
//   clock         - system clock, rising edge
//   clear_n       - asynchronous active-low reset
//   data_in       - byte to transmit
//   data_in_valid - data_in is valid this cycle
//   data_in_ready - holding register empty (registered)
//   uart_tx       - serial line, registered, idles high
//   busy          - a frame is being driven
module uart_transmitter #(
    parameter int unsigned CLOCKS_PER_BIT = 10000,
    parameter int unsigned PARITY         = 0,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       uart_tx,
    output logic       busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam logic [13:0] CNT_LAST  = 14'(CLOCKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam bit          PAR_EN    = (PARITY != 0);
    localparam bit          PAR_ODD   = (PARITY == 1);

    state_t      state;
    logic [13:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        parity_bit;
    logic [7:0]  holding;
    logic        holding_full;

    logic cnt_last;
    logic stop_done;
    logic accept;
    logic load_shift;

    assign cnt_last  = (clk_cnt == CNT_LAST);
    // bit_idx doubles as the stop-bit counter while in STOP
    assign stop_done = (state == ST_STOP) && cnt_last
                       && (bit_idx == STOP_LAST);
    assign accept    = data_in_valid && data_in_ready;
    assign load_shift = holding_full
                        && ((state == ST_IDLE) || stop_done);

    // Holding register; ready is registered so it never follows valid.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            holding       <= 8'h00;
            holding_full  <= 1'b0;
            data_in_ready <= 1'b1;
        end else begin
            if (accept) begin
                holding      <= data_in;
                holding_full <= 1'b1;
            end else if (load_shift) begin
                holding_full <= 1'b0;
            end
            data_in_ready <= !(accept || (holding_full && !load_shift));
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state      <= ST_IDLE;
            clk_cnt    <= 14'd0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            uart_tx    <= 1'b1;
            busy       <= 1'b0;
        end else if (load_shift) begin
            // Parity is latched from the whole byte before shifting starts
            state      <= ST_START;
            clk_cnt    <= 14'd0;
            bit_idx    <= 3'd0;
            shift      <= holding;
            parity_bit <= PAR_ODD ? ~^holding : ^holding;
            uart_tx    <= 1'b0;
            busy       <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                end
                ST_START: begin
                    if (cnt_last) begin
                        state   <= ST_DATA;
                        clk_cnt <= 14'd0;
                        uart_tx <= shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 14'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_last) begin
                        clk_cnt <= 14'd0;
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PAR_EN) begin
                                state   <= ST_PARITY;
                                uart_tx <= parity_bit;
                            end else begin
                                state   <= ST_STOP;
                                uart_tx <= 1'b1;
                            end
                        end else begin
                            uart_tx <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 14'd1;
                    end
                end
                ST_PARITY: begin
                    if (cnt_last) begin
                        state   <= ST_STOP;
                        clk_cnt <= 14'd0;
                        bit_idx <= 3'd0;
                        uart_tx <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 14'd1;
                    end
                end
                ST_STOP: begin
                    if (cnt_last) begin
                        clk_cnt <= 14'd0;
                        if (bit_idx == STOP_LAST) begin
                            state   <= ST_IDLE;
                            bit_idx <= 3'd0;
                            busy    <= 1'b0;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 14'd1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    uart_tx <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: three configurations
// (8N1, 8O1, 8E2) driven with directed and random bytes.
module tb_uart_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int lanes_done = 0;

    task automatic chk(input string name, input int lane,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h, want %0h (cycle %0d)",
                     name, lane, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int CPB = (g == 2) ? 2 : 4;
        localparam int PAR = g;
        localparam int SB  = (g == 2) ? 2 : 1;
        localparam int NB  = 1 + 8 + ((PAR != 0) ? 1 : 0) + SB;

        logic       rst_n = 1'b0;
        logic [7:0] din   = 8'h00;
        logic       valid = 1'b0;
        logic       ready;
        logic       tx;
        logic       busy;

        uart_transmitter #(
            .CLOCKS_PER_BIT(CPB),
            .PARITY(PAR),
            .STOP_BITS(SB)
        ) dut (
            .clock(clk),
            .clear_n(rst_n),
            .data_in(din),
            .data_in_valid(valid),
            .data_in_ready(ready),
            .uart_tx(tx),
            .busy(busy)
        );

        // Scoreboard: bytes and the edge on which each was accepted
        logic [7:0] q_byte[$];
        int         q_acc[$];
        int         last_end = 0;

        // Call at a negedge; returns at the negedge after acceptance.
        task automatic send(input logic [7:0] b);
            bit ok = 0;
            din   = b;
            valid = 1'b1;
            for (int n = 0; n < 300 && !ok; n++) begin
                if (ready === 1'b1) begin
                    q_byte.push_back(b);
                    q_acc.push_back(cyc + 1);
                    ok = 1;
                end
                @(negedge clk);
            end
            valid = 1'b0;
            din   = 8'($urandom);
            if (!ok) chk("accept_timeout", g, 0, 1);
            else chk("ready_after_accept", g, 32'(ready), 0);
        endtask

        task automatic wait_idle();
            bit ok = 0;
            for (int n = 0; n < 2000 && !ok; n++) begin
                @(negedge clk);
                if (busy === 1'b0 && q_byte.size() == 0) ok = 1;
            end
            if (!ok) chk("idle_timeout", g, 0, 1);
        endtask

        // Monitor: recognises a start bit and compares the whole frame
        initial begin
            logic [7:0] b;
            int         acc;
            int         s_exp;
            int         s_act;
            int         idx;
            logic       ex [NB];
            logic [1:0] got;
            bit         abort;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) continue;
                if (tx !== 1'b0) begin
                    if (busy !== 1'b0) chk("idle_busy", g, 32'(busy), 0);
                    continue;
                end
                if (q_byte.size() == 0) begin
                    chk("unexpected_frame", g, 1, 0);
                    repeat (NB * CPB - 1) @(negedge clk);
                    continue;
                end
                b     = q_byte.pop_front();
                acc   = q_acc.pop_front();
                s_exp = (acc + 1 > last_end) ? acc + 1 : last_end;
                s_act = cyc;
                chk("start_edge", g, s_act, s_exp);
                ex[0] = 1'b0;
                for (int i = 0; i < 8; i++) ex[1 + i] = b[i];
                idx = 9;
                if (PAR != 0) begin
                    if (PAR == 2) ex[idx] = ($countones(b) % 2) == 1;
                    else ex[idx] = ($countones(b) % 2) == 0;
                    idx++;
                end
                for (int s = 0; s < SB; s++) ex[idx + s] = 1'b1;
                abort = 0;
                for (int i = 0; i < NB && !abort; i++) begin
                    got = {ex[i], 1'b1};
                    for (int k = 0; k < CPB && !abort; k++) begin
                        if (i != 0 || k != 0) @(negedge clk);
                        if (rst_n !== 1'b1) abort = 1;
                        else if ((tx !== ex[i] || busy !== 1'b1)
                                 && got === {ex[i], 1'b1})
                            got = {tx, busy};
                    end
                    if (!abort)
                        chk($sformatf("frame_%02h_bit%0d", b, i), g,
                            32'(got), 32'({ex[i], 1'b1}));
                end
                if (!abort) last_end = s_act + NB * CPB;
            end
        end

        // Driver
        initial begin
            int gap;
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            chk("reset_tx", g, 32'(tx), 1);
            chk("reset_busy", g, 32'(busy), 0);
            chk("reset_ready", g, 32'(ready), 1);
            rst_n = 1'b1;
            @(negedge clk);
            chk("release_tx", g, 32'(tx), 1);
            chk("release_ready", g, 32'(ready), 1);

            send(8'hA5);
            wait_idle();
            send(8'h00);
            repeat (3 * CPB) @(negedge clk);
            send(8'hFF);
            send(8'h07);
            send(8'h3C);
            send(8'h81);
            wait_idle();

            repeat (24) begin
                send(8'($urandom));
                gap = ($urandom_range(0, 2) == 0)
                      ? $urandom_range(0, NB * CPB + 2) : 0;
                repeat (gap) @(negedge clk);
            end
            wait_idle();

            // Asynchronous reset mid-frame with a byte queued
            send(8'h96);
            repeat (3 * CPB) @(negedge clk);
            send(8'h69);
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            q_byte.delete();
            q_acc.delete();
            last_end = 0;
            #1;
            chk("async_tx", g, 32'(tx), 1);
            chk("async_busy", g, 32'(busy), 0);
            chk("async_ready", g, 32'(ready), 1);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (2 * NB * CPB) @(negedge clk);
            send(8'hC3);
            wait_idle();
            lanes_done++;
        end
    end

    initial begin
        for (int n = 0; n < 60000 && lanes_done < 3; n++) @(negedge clk);
        if (lanes_done < 3) chk("global_timeout", 0, lanes_done, 3);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
